// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU port (m0), the debug/loader port (m1), the
// data-memory arbiter and the single-port synchronous data memory.
interface dmem_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          m0_req, m0_we, m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req, m1_we, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          wr, rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data;

  logic          owner, lock_err;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  rd_data,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output wr, rd, addr, wr_data, owner, lock_err
  );

  // Requester / memory side
  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output rd_data,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  wr, rd, addr, wr_data, owner, lock_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for a single-port synchronous data memory,
// with bounded bus locking and a sticky lock-timeout flag.
module dmem_arbiter #(
  parameter int AW       = 9,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

  typedef enum logic [2:0] {IDLE, OWN0, OWN1, LOCK0, LOCK1} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          blk0_q, blk0_d, blk1_q, blk1_d;
  logic          req0, req1, gnt0, gnt1;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] wdata_p0;
  logic          vld0_p1, vld1_p1;

  // p0: grant decision and memory command, all in the request cycle
  assign req0 = bus.m0_req & ~reset;
  assign req1 = bus.m1_req & ~reset;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    // A blocked lock re-arms only once the requester has let go of it.
    blk0_d  = blk0_q & bus.m0_lock;
    blk1_d  = blk1_q & bus.m1_lock;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      LOCK0: begin
        gnt0   = req0;
        last_d = 1'b0;
        if (!bus.m0_lock) begin
          state_d = OWN0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = OWN0;
          cnt_d   = '0;
          err_d   = 1'b1;
          blk0_d  = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      LOCK1: begin
        gnt1   = req1;
        last_d = 1'b1;
        if (!bus.m1_lock) begin
          state_d = OWN1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = OWN1;
          cnt_d   = '0;
          err_d   = 1'b1;
          blk1_d  = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        if (req0 && req1) begin
          gnt0 = last_q;
          gnt1 = ~last_q;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
        cnt_d = '0;
        if (gnt0) begin
          last_d  = 1'b0;
          state_d = (bus.m0_lock && !blk0_q) ? LOCK0 : OWN0;
        end else if (gnt1) begin
          last_d  = 1'b1;
          state_d = (bus.m1_lock && !blk1_q) ? LOCK1 : OWN1;
        end
      end
    endcase
  end

  always_comb begin
    addr_p0  = '0;
    wdata_p0 = '0;
    if (gnt0) begin
      addr_p0  = bus.m0_addr;
      wdata_p0 = bus.m0_wdata;
    end else if (gnt1) begin
      addr_p0  = bus.m1_addr;
      wdata_p0 = bus.m1_wdata;
    end
  end

  assign bus.m0_gnt  = gnt0;
  assign bus.m1_gnt  = gnt1;
  assign bus.wr      = (gnt0 & bus.m0_we) | (gnt1 & bus.m1_we);
  assign bus.rd      = (gnt0 & ~bus.m0_we) | (gnt1 & ~bus.m1_we);
  assign bus.addr    = addr_p0;
  assign bus.wr_data = wdata_p0;
  assign bus.owner   = gnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      blk0_q  <= 1'b0;
      blk1_q  <= 1'b0;
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      blk0_q  <= blk0_d;
      blk1_q  <= blk1_d;
      vld0_p1 <= gnt0 & ~bus.m0_we;
      vld1_p1 <= gnt1 & ~bus.m1_we;
    end
  end

  // p1: read data returns from memory one cycle after the grant
  assign bus.m0_rvalid = vld0_p1;
  assign bus.m1_rvalid = vld1_p1;
  assign bus.m0_rdata  = vld0_p1 ? bus.rd_data : '0;
  assign bus.m1_rdata  = vld1_p1 ? bus.rd_data : '0;
  assign bus.lock_err  = err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous data memory.
module tb_dmem_arbiter;
  logic tb_clk = 1'b0;
  logic reset  = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;

  logic        pl_we   = 1'b0;
  logic [8:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] mem [0:511];
  logic [31:0] rd_q;

  dmem_arbiter_if #(.AW(9), .DW(32)) ifc ();

  dmem_arbiter #(.AW(9), .DW(32), .LOCK_MAX(8)) dut (
    .clk   (tb_clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 tb_clk = ~tb_clk;

  always @(posedge tb_clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ifc.wr) mem[ifc.addr] <= ifc.wr_data;
    if (ifc.rd) rd_q <= mem[ifc.addr];
  end
  assign ifc.rd_data = rd_q;

  task automatic clear_inputs();
    ifc.m0_req = 0; ifc.m0_we = 0; ifc.m0_lock = 0; ifc.m0_addr = '0; ifc.m0_wdata = '0;
    ifc.m1_req = 0; ifc.m1_we = 0; ifc.m1_lock = 0; ifc.m1_addr = '0; ifc.m1_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge tb_clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge tb_clk);
    reset = 1'b0;
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    @(negedge tb_clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge tb_clk);
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge tb_clk);
    ifc.m0_req = 1; ifc.m1_req = 1; ifc.m0_addr = 9'h11; ifc.m1_addr = 9'h22;
    #1;
    n_cmp++; if (ifc.m0_gnt !== 1'b0) begin n_err++; $display("FAIL rst_gnt0: got %0b want 0", ifc.m0_gnt); end
    n_cmp++; if (ifc.m1_gnt !== 1'b0) begin n_err++; $display("FAIL rst_gnt1: got %0b want 0", ifc.m1_gnt); end
    n_cmp++; if ({ifc.wr, ifc.rd, ifc.owner} !== 3'b000) begin n_err++; $display("FAIL rst_wr_rd_owner: got %b want 000", {ifc.wr, ifc.rd, ifc.owner}); end
    n_cmp++; if (ifc.addr !== 9'h0) begin n_err++; $display("FAIL rst_addr: got %0h want 0", ifc.addr); end
    n_cmp++; if ({ifc.m0_rvalid, ifc.m1_rvalid, ifc.lock_err} !== 3'b000) begin n_err++; $display("FAIL rst_vld_err: got %b want 000", {ifc.m0_rvalid, ifc.m1_rvalid, ifc.lock_err}); end
    clear_inputs();
  endtask

  task automatic test_read();
    @(negedge tb_clk);
    reset = 1'b0;
    ifc.m0_req = 1; ifc.m0_we = 0; ifc.m0_addr = 9'd5;
    #1;
    n_cmp++; if (ifc.m0_gnt !== 1'b1) begin n_err++; $display("FAIL rd_gnt0: got %0b want 1", ifc.m0_gnt); end
    n_cmp++; if ({ifc.rd, ifc.wr} !== 2'b10) begin n_err++; $display("FAIL rd_cmd: got rd,wr=%b want 10", {ifc.rd, ifc.wr}); end
    n_cmp++; if (ifc.addr !== 9'd5) begin n_err++; $display("FAIL rd_addr: got %0h want 5", ifc.addr); end
    n_cmp++; if ({ifc.m1_gnt, ifc.owner} !== 2'b00) begin n_err++; $display("FAIL rd_m1_idle: got %b want 00", {ifc.m1_gnt, ifc.owner}); end
    @(negedge tb_clk);
    ifc.m0_req = 0;
    #1;
    n_cmp++; if (ifc.m0_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_rvalid: got %0b want 1", ifc.m0_rvalid); end
    n_cmp++; if (ifc.m0_rdata !== 32'h0000_00AA) begin n_err++; $display("FAIL rd_rdata: got %h want 000000aa", ifc.m0_rdata); end
    n_cmp++; if ({ifc.m1_rvalid, ifc.m1_rdata} !== 33'h0) begin n_err++; $display("FAIL rd_m1_out: got %h want 0", {ifc.m1_rvalid, ifc.m1_rdata}); end
    @(negedge tb_clk);
    #1;
    n_cmp++; if ({ifc.m0_rvalid, ifc.m0_rdata} !== 33'h0) begin n_err++; $display("FAIL rd_rvalid_drop: got %h want 0", {ifc.m0_rvalid, ifc.m0_rdata}); end
  endtask

  task automatic test_round_robin();
    logic e0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge tb_clk);
      ifc.m0_req = 1; ifc.m0_addr = 9'd10;
      ifc.m1_req = 1; ifc.m1_addr = 9'd20;
      #1;
      e0 = (i % 2 == 0);
      n_cmp++; if ({ifc.m0_gnt, ifc.m1_gnt} !== {e0, ~e0}) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, {ifc.m0_gnt, ifc.m1_gnt}, {e0, ~e0}); end
      n_cmp++; if ((ifc.wr & ifc.rd) !== 1'b0) begin n_err++; $display("FAIL rr_wr_rd[%0d]: got wr&rd=1 want 0", i); end
      if (i > 0) begin
        n_cmp++; if ({ifc.m0_rvalid, ifc.m1_rvalid} !== {~e0, e0}) begin n_err++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, {ifc.m0_rvalid, ifc.m1_rvalid}, {~e0, e0}); end
      end
    end
    @(negedge tb_clk);
    clear_inputs();
    #1;
    n_cmp++; if ({ifc.m0_rvalid, ifc.m1_rvalid} !== 2'b01) begin n_err++; $display("FAIL rr_last_rvalid: got %b want 01", {ifc.m0_rvalid, ifc.m1_rvalid}); end
  endtask

  task automatic test_lock();
    do_reset();
    @(negedge tb_clk);
    ifc.m1_req = 1; ifc.m1_we = 1; ifc.m1_lock = 1; ifc.m1_addr = 9'h1FF; ifc.m1_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if ({ifc.m1_gnt, ifc.wr, ifc.rd, ifc.owner} !== 4'b1101) begin n_err++; $display("FAIL lk_gnt1: got gnt,wr,rd,owner=%b want 1101", {ifc.m1_gnt, ifc.wr, ifc.rd, ifc.owner}); end
    n_cmp++; if ({ifc.addr, ifc.wr_data} !== {9'h1FF, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL lk_wdata: got %h/%h want 1ff/deadbeef", ifc.addr, ifc.wr_data); end
    for (int i = 1; i < 3; i++) begin
      @(negedge tb_clk);
      ifc.m0_req = 1; ifc.m0_we = 0; ifc.m0_addr = 9'd7;
      #1;
      n_cmp++; if ({ifc.m0_gnt, ifc.m1_gnt} !== 2'b01) begin n_err++; $display("FAIL lk_hold[%0d]: got %b want 01", i, {ifc.m0_gnt, ifc.m1_gnt}); end
    end
    @(negedge tb_clk);
    ifc.m1_req = 0; ifc.m1_lock = 0; ifc.m1_we = 0;
    #1;
    n_cmp++; if ({ifc.m0_gnt, ifc.m1_gnt, ifc.rd} !== 3'b000) begin n_err++; $display("FAIL lk_drop: got gnt0,gnt1,rd=%b want 000", {ifc.m0_gnt, ifc.m1_gnt, ifc.rd}); end
    @(negedge tb_clk);
    #1;
    n_cmp++; if ({ifc.m0_gnt, ifc.rd, ifc.addr} !== {2'b11, 9'd7}) begin n_err++; $display("FAIL lk_after: got gnt0=%0b rd=%0b addr=%0h want 1 1 7", ifc.m0_gnt, ifc.rd, ifc.addr); end
    @(negedge tb_clk);
    clear_inputs();
  endtask

  task automatic test_lock_timeout();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge tb_clk);
      ifc.m0_req = 1; ifc.m0_lock = 1; ifc.m0_addr = 9'd2;
      ifc.m1_req = (k >= 1); ifc.m1_addr = 9'd30;
      #1;
      if (k <= 8) begin
        n_cmp++; if ({ifc.m0_gnt, ifc.m1_gnt, ifc.lock_err} !== 3'b100) begin n_err++; $display("FAIL to_locked[%0d]: got gnt0,gnt1,err=%b want 100", k, {ifc.m0_gnt, ifc.m1_gnt, ifc.lock_err}); end
      end else if (k <= 11) begin
        n_cmp++; if ({ifc.m0_gnt, ifc.m1_gnt, ifc.lock_err} !== {(k == 10), (k != 10), 1'b1}) begin n_err++; $display("FAIL to_exit[%0d]: got gnt0,gnt1,err=%b want %b", k, {ifc.m0_gnt, ifc.m1_gnt, ifc.lock_err}, {(k == 10), (k != 10), 1'b1}); end
      end
    end
    @(negedge tb_clk);
    clear_inputs();
    #1;
    n_cmp++; if (ifc.lock_err !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %0b want 1", ifc.lock_err); end
  endtask

  task automatic test_reset_read();
    @(negedge tb_clk);
    ifc.m1_req = 1; ifc.m1_we = 0; ifc.m1_addr = 9'd4;
    #1;
    n_cmp++; if (ifc.m1_gnt !== 1'b1) begin n_err++; $display("FAIL rr_m1_gnt: got %0b want 1", ifc.m1_gnt); end
    @(negedge tb_clk);
    ifc.m1_req = 0; ifc.m0_req = 1;
    #1;
    n_cmp++; if (ifc.m1_rvalid !== 1'b1) begin n_err++; $display("FAIL rst_pre_rvalid: got %0b want 1", ifc.m1_rvalid); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({ifc.m1_rvalid, ifc.m1_rdata} !== 33'h0) begin n_err++; $display("FAIL rst_async_rvalid: got %h want 0", {ifc.m1_rvalid, ifc.m1_rdata}); end
    n_cmp++; if ({ifc.m0_gnt, ifc.m1_gnt, ifc.wr, ifc.rd, ifc.owner, ifc.lock_err} !== 6'b0) begin n_err++; $display("FAIL rst_async_out: got %b want 000000", {ifc.m0_gnt, ifc.m1_gnt, ifc.wr, ifc.rd, ifc.owner, ifc.lock_err}); end
    n_cmp++; if ({ifc.addr, ifc.wr_data} !== 41'h0) begin n_err++; $display("FAIL rst_async_bus: got %h want 0", {ifc.addr, ifc.wr_data}); end
    @(negedge tb_clk);
    clear_inputs();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge tb_clk);
      #1;
      n_cmp++; if ({ifc.m1_rvalid, ifc.m0_rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_no_rvalid[%0d]: got %b want 00", i, {ifc.m1_rvalid, ifc.m0_rvalid}); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge tb_clk);
    ifc.m0_req = 1; ifc.m0_we = 1; ifc.m0_addr = 9'd3; ifc.m0_wdata = 32'h12;
    #1;
    n_cmp++; if ({ifc.m0_gnt, ifc.wr, ifc.addr, ifc.wr_data} !== {2'b11, 9'd3, 32'h12}) begin n_err++; $display("FAIL b2b_wr: got gnt0=%0b wr=%0b addr=%0h data=%h want 1 1 3 12", ifc.m0_gnt, ifc.wr, ifc.addr, ifc.wr_data); end
    @(negedge tb_clk);
    ifc.m0_req = 0; ifc.m0_we = 0;
    ifc.m1_req = 1; ifc.m1_we = 0; ifc.m1_addr = 9'd3;
    #1;
    n_cmp++; if ({ifc.m1_gnt, ifc.rd, ifc.owner, ifc.addr} !== {3'b111, 9'd3}) begin n_err++; $display("FAIL b2b_rd: got gnt1=%0b rd=%0b owner=%0b addr=%0h want 1 1 1 3", ifc.m1_gnt, ifc.rd, ifc.owner, ifc.addr); end
    @(negedge tb_clk);
    clear_inputs();
    #1;
    n_cmp++; if ({ifc.m1_rvalid, ifc.m1_rdata} !== {1'b1, 32'h12}) begin n_err++; $display("FAIL b2b_raw: got rvalid=%0b rdata=%h want 1 00000012", ifc.m1_rvalid, ifc.m1_rdata); end
    n_cmp++; if (ifc.m0_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_m0_rvalid: got %0b want 0", ifc.m0_rvalid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    preload(9'd5, 32'h0000_00AA);
    test_reset();
    test_read();
    test_round_robin();
    test_lock();
    test_lock_timeout();
    test_reset_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
